mont_redc: RTL and testbench
============================

// Module: mont_redc
// PURPOSE
//  Word-serial Montgomery reduction (REDC): result = t_in * R^-1 mod n, with R = 2^(WORD_W*NUM_WORDS).
//  Consumes the 64-bit n_inv (= -n^-1 mod 2^64) and its valid flag produced by the modular-inverse engine.
//  Sits between the modular-inverse engine and the RSA exponentiation datapath.
//  Uses one WORD_W x WORD_W multiply-accumulate per cycle.
// PARAMETERS
//  WORD_W     64  digit width; must equal width of n_inv
//  NUM_WORDS  64  digits per modulus; N = WORD_W*NUM_WORDS (4096)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  go         in   1        start request, sampled in IDLE only
//  t_in       in   2N       value to reduce; precondition t_in < n*R
//  n          in   N        odd modulus, captured at start
//  n_inv      in   WORD_W   -n^-1 mod 2^WORD_W
//  inv_valid  in   1        n_inv is valid (inverse engine's valid)
//  busy       out  1        high from accepted go until valid rises
//  result     out  N        reduced value, 0 <= result < n
//  valid      out  1        result ready; level, held until next accepted go
//  err        out  1        one-cycle pulse: go refused because inv_valid=0
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy=0, valid=0, err=0, result=0, all internal registers cleared.
//  States: IDLE -> LOAD -> CALC_M -> MAC -> SHIFT -> (CALC_M | SUB) -> FINAL -> IDLE.
//  IDLE: go & inv_valid -> LOAD. go & !inv_valid -> err=1 for 1 cycle, stay IDLE. go while busy is ignored.
//  LOAD: capture t_in into T[0..2*NUM_WORDS] (extra top word = 0), n, n_inv; i=0; valid<=0; busy<=1.
//  CALC_M: m = (T[0]*n_inv) mod 2^WORD_W; j=0; carry c=0.
//  MAC (NUM_WORDS cycles, j=0..NUM_WORDS-1): {c,T[j]} = T[j] + m*n[j] + c.
//    The 2*WORD_W-bit sum never overflows.
//  SHIFT (1 cycle): T = (T + (c << N)) >> WORD_W. This is the only wide add. T[0] is 0 before the shift.
//    i++; if i<NUM_WORDS -> CALC_M, else -> SUB.
//  SUB (NUM_WORDS cycles): D[j] = T[j] - n[j] - borrow, word-serial ripple borrow.
//  FINAL (1 cycle): T has N+1 significant bits and T < 2n.
//    If T[NUM_WORDS]!=0 or final borrow==0, result<=D; otherwise result<=T[N-1:0].
//    valid<=1; busy<=0; -> IDLE.
//  Latency, go accepted -> valid high: 1 + NUM_WORDS*(NUM_WORDS+2) + NUM_WORDS + 1 cycles. Fixed, data-independent.
//  Inputs are sampled only in LOAD. Changes to t_in, n or n_inv mid-operation have no effect.
//  inv_valid falling mid-operation has no effect.
//  go coincident with FINAL is ignored. go in the cycle after valid rises is accepted, and valid clears in LOAD.
//  Preconditions: n odd, n > 1, t_in < n*R. The output is unspecified (but still bounded) if these are violated.
//  No internal check is made on the preconditions.
// STRUCTURE
//  Package rsa_pkg: WORD_W, NUM_WORDS, derived N, and the state enum
//    (ST_IDLE, ST_LOAD, ST_CALC_M, ST_MAC, ST_SHIFT, ST_SUB, ST_FINAL).
//  Sub-module mont_mac_word: combinational a*b + x + y -> {hi,lo}, all WORD_W wide.
//    It is shared between CALC_M (lo only) and MAC.
//  Counters i, j: $clog2(NUM_WORDS+1) bits each.
// TESTING (bench uses NUM_WORDS=2, N=128; n = 2^128-159; n_inv from the golden model / inverse engine)
//  t_in=0, go -> valid after exactly 12 cycles, result=0, busy high for cycles 1..11.
//  t_in=2^128 (=R) -> result=1. t_in=5*2^128 -> result=5.
//  t_in=n -> result=0. t_in=n*R-1 -> result equals the model. Exercises the FINAL subtract path (D selected).
//  go with inv_valid=0 -> err pulses 1 cycle, busy and valid stay 0, no state change.
//  rst asserted mid-MAC -> all outputs 0 immediately. A following go with t_in=R yields result=1 after 12 cycles.
//  Second go during busy is ignored. Back-to-back go the cycle after valid -> valid drops, new result after 12 cycles.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared sizing constants and controller state encoding for the RSA datapath.
package rsa_pkg;

  localparam int unsigned WORD_W    = 64;
  localparam int unsigned NUM_WORDS = 64;
  localparam int unsigned N         = WORD_W * NUM_WORDS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC_M,
    ST_MAC,
    ST_SHIFT,
    ST_SUB,
    ST_FINAL
  } state_t;

endpackage

// File: rtl/mont_mac_word.sv
// One-word multiply-accumulate: {hi,lo} = a*b + x + y.
// The 2*WORD_W-bit result cannot overflow: (2^W-1)^2 + 2*(2^W-1) = 2^(2W)-1.
module mont_mac_word #(
  parameter int unsigned WORD_W = rsa_pkg::WORD_W
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo
);
  import rsa_pkg::*;

  logic [2*WORD_W-1:0] acc;

  // Full-width product plus two addends
  always_comb begin
    acc = ({{WORD_W{1'b0}}, a} * {{WORD_W{1'b0}}, b})
        + {{WORD_W{1'b0}}, x}
        + {{WORD_W{1'b0}}, y};
  end

  assign hi = acc[2*WORD_W-1:WORD_W];
  assign lo = acc[WORD_W-1:0];

endmodule

// File: rtl/mont_redc.sv
// Word-serial Montgomery reduction: result = t_in * R^-1 mod n, R = 2^(WORD_W*NUM_WORDS).
// One WORD_W x WORD_W multiply-accumulate per cycle, shared between the
// quotient-digit computation (CALC_M) and the row accumulation (MAC).
module mont_redc #(
  parameter int unsigned WORD_W    = rsa_pkg::WORD_W,
  parameter int unsigned NUM_WORDS = rsa_pkg::NUM_WORDS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             go,
  input  logic [2*WORD_W*NUM_WORDS-1:0]    t_in,
  input  logic [WORD_W*NUM_WORDS-1:0]      n,
  input  logic [WORD_W-1:0]                n_inv,
  input  logic                             inv_valid,
  output logic                             busy,
  output logic [WORD_W*NUM_WORDS-1:0]      result,
  output logic                             valid,
  output logic                             err
);
  import rsa_pkg::*;

  localparam int unsigned NB = WORD_W * NUM_WORDS;
  localparam int unsigned TW = (2 * NUM_WORDS + 1) * WORD_W;
  localparam int unsigned CW = $clog2(NUM_WORDS + 1);

  state_t              state;
  logic [TW-1:0]       t_r;
  logic [NB-1:0]       n_r;
  logic [NB-1:0]       d_r;
  logic [WORD_W-1:0]   ninv_r;
  logic [WORD_W-1:0]   m_r;
  logic [WORD_W-1:0]   c_r;
  logic [CW-1:0]       i_r;
  logic [CW-1:0]       j_r;
  logic                bw_r;

  logic [WORD_W-1:0]   t_j;
  logic [WORD_W-1:0]   n_j;
  logic [WORD_W-1:0]   t_0;
  logic [WORD_W-1:0]   t_top;

  logic [WORD_W-1:0]   mac_a;
  logic [WORD_W-1:0]   mac_b;
  logic [WORD_W-1:0]   mac_x;
  logic [WORD_W-1:0]   mac_y;
  logic [WORD_W-1:0]   mac_hi;
  logic [WORD_W-1:0]   mac_lo;

  logic [WORD_W:0]     sub_w;
  logic [TW-1:0]       shifted;

  assign t_j   = t_r[WORD_W*32'(j_r) +: WORD_W];
  assign n_j   = n_r[WORD_W*32'(j_r) +: WORD_W];
  assign t_0   = t_r[WORD_W-1:0];
  assign t_top = t_r[NB +: WORD_W];

  // Operand select for the shared MAC: quotient digit in CALC_M, row update otherwise
  always_comb begin
    mac_a = m_r;
    mac_b = n_j;
    mac_x = t_j;
    mac_y = c_r;
    if (state == ST_CALC_M) begin
      mac_a = t_0;
      mac_b = ninv_r;
      mac_x = '0;
      mac_y = '0;
    end
  end

  mont_mac_word #(.WORD_W(WORD_W)) u_mac (
    .a  (mac_a),
    .b  (mac_b),
    .x  (mac_x),
    .y  (mac_y),
    .hi (mac_hi),
    .lo (mac_lo)
  );

  // Word-serial subtract of n with ripple borrow, and the end-of-row carry fold plus word shift
  always_comb begin
    sub_w   = {1'b0, t_j} - {1'b0, n_j} - {{WORD_W{1'b0}}, bw_r};
    shifted = (t_r + ({{(TW-WORD_W){1'b0}}, c_r} << NB)) >> WORD_W;
  end

  // Controller and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      t_r    <= '0;
      n_r    <= '0;
      d_r    <= '0;
      ninv_r <= '0;
      m_r    <= '0;
      c_r    <= '0;
      i_r    <= '0;
      j_r    <= '0;
      bw_r   <= 1'b0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            if (inv_valid) state <= ST_LOAD;
            else           err   <= 1'b1;
          end
        end
        ST_LOAD: begin
          t_r    <= {{WORD_W{1'b0}}, t_in};
          n_r    <= n;
          ninv_r <= n_inv;
          i_r    <= '0;
          valid  <= 1'b0;
          busy   <= 1'b1;
          state  <= ST_CALC_M;
        end
        ST_CALC_M: begin
          m_r   <= mac_lo;
          j_r   <= '0;
          c_r   <= '0;
          state <= ST_MAC;
        end
        ST_MAC: begin
          t_r[WORD_W*32'(j_r) +: WORD_W] <= mac_lo;
          c_r <= mac_hi;
          if (j_r == CW'(NUM_WORDS - 1)) begin
            state <= ST_SHIFT;
          end else begin
            j_r <= j_r + CW'(1);
          end
        end
        ST_SHIFT: begin
          t_r <= shifted;
          i_r <= i_r + CW'(1);
          if (i_r == CW'(NUM_WORDS - 1)) begin
            j_r   <= '0;
            bw_r  <= 1'b0;
            state <= ST_SUB;
          end else begin
            state <= ST_CALC_M;
          end
        end
        ST_SUB: begin
          d_r[WORD_W*32'(j_r) +: WORD_W] <= sub_w[WORD_W-1:0];
          bw_r <= sub_w[WORD_W];
          if (j_r == CW'(NUM_WORDS - 1)) begin
            state <= ST_FINAL;
          end else begin
            j_r <= j_r + CW'(1);
          end
        end
        ST_FINAL: begin
          // T < 2n: subtracted value wins when T overflows N bits or T >= n
          if (t_top != '0 || !bw_r) result <= d_r;
          else                      result <= t_r[NB-1:0];
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_redc.sv
// Bench for mont_redc at WORD_W=64, NUM_WORDS=2 (N=128), n = 2^128-159.
module tb_mont_redc;

  localparam int unsigned WW = 64;
  localparam int unsigned NW = 2;
  localparam logic [127:0] N_MOD = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF61;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         go = 1'b0;
  logic [255:0] t_in = '0;
  logic [127:0] n = N_MOD;
  logic [63:0]  n_inv = '0;
  logic         inv_valid = 1'b0;
  logic         busy;
  logic [127:0] result;
  logic         valid;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  logic [63:0]  ninv_good;
  logic [255:0] r_val;

  always #5 clk = ~clk;

  mont_redc #(.WORD_W(WW), .NUM_WORDS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .t_in      (t_in),
    .n         (n),
    .n_inv     (n_inv),
    .inv_valid (inv_valid),
    .busy      (busy),
    .result    (result),
    .valid     (valid),
    .err       (err)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // t * 2^-128 mod n by reducing t and halving modulo n 128 times
  function automatic logic [127:0] redc_model(input logic [255:0] t);
    logic [255:0] rem;
    logic [128:0] x;
    rem = t % {128'b0, N_MOD};
    x = rem[128:0];
    for (int k = 0; k < 128; k++) begin
      if (x[0]) x = (x + {1'b0, N_MOD}) >> 1;
      else      x = x >> 1;
    end
    return x[127:0];
  endfunction

  // -n^-1 mod 2^64 by Newton iteration
  function automatic logic [63:0] calc_ninv();
    logic [127:0] nm;
    logic [63:0]  n0;
    logic [63:0]  inv;
    nm = N_MOD;
    n0 = nm[63:0];
    inv = n0;
    for (int k = 0; k < 6; k++) inv = inv * (64'd2 - n0 * inv);
    return -inv;
  endfunction

  // Transaction-level model: an accepted go fixes a 12-edge timeline
  bit           m_act;
  int           m_age;
  logic         m_busy, m_valid, m_err;
  logic [127:0] m_result, m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act    <= 1'b0;
      m_age    <= 0;
      m_busy   <= 1'b0;
      m_valid  <= 1'b0;
      m_err    <= 1'b0;
      m_result <= '0;
      m_pend   <= '0;
    end else begin
      m_err <= 1'b0;
      if ((!m_act || m_age >= 12) && go) begin
        if (inv_valid) begin
          m_act <= 1'b1;
          m_age <= 0;
        end else begin
          m_err <= 1'b1;
        end
      end else if (m_act && m_age < 12) begin
        m_age <= m_age + 1;
        if (m_age == 0) begin
          m_busy  <= 1'b1;
          m_valid <= 1'b0;
          m_pend  <= redc_model(t_in);
        end
        if (m_age == 11) begin
          m_busy   <= 1'b0;
          m_valid  <= 1'b1;
          m_result <= m_pend;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_on && !rst) begin
      check("busy", {255'b0, busy}, {255'b0, m_busy});
      check("valid", {255'b0, valid}, {255'b0, m_valid});
      check("err", {255'b0, err}, {255'b0, m_err});
      check("result", {128'b0, result}, {128'b0, m_result});
    end
  end

  // Caller is positioned at a negedge; go is sampled at the next rising edge
  task automatic run_op(input logic [255:0] t, input bit has_lit, input logic [127:0] lit,
                        input int poke, input bit b2b);
    int lat;
    bit done;
    t_in = t;
    n = N_MOD;
    n_inv = ninv_good;
    inv_valid = 1'b1;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    done = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40 && !done; k++) begin
      @(negedge clk);
      go = (k == poke);
      if (k == poke) t_in = r_val;
      if (k == 3) begin
        t_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        n = ~N_MOD;
        n_inv = ~ninv_good;
        inv_valid = 1'b0;
      end
      if (k == 2 && b2b) check("b2b_valid_drop", {255'b0, valid}, 256'd0);
      if (k >= 2 && valid) begin
        done = 1'b1;
        lat = k;
      end
    end
    go = 1'b0;
    check("latency", 256'(lat), 256'd12);
    if (has_lit) check("result_lit", {128'b0, result}, {128'b0, lit});
    else         check("result_model", {128'b0, result}, {128'b0, redc_model(t)});
  endtask

  initial begin
    logic [63:0]  nlow;
    logic [127:0] nm;
    logic [255:0] nr_m1;
    r_val = 256'd1 << 128;
    ninv_good = calc_ninv();
    nm = N_MOD;
    nlow = nm[63:0];
    nr_m1 = ({128'b0, N_MOD} << 128) - 256'd1;

    repeat (3) @(negedge clk);
    check("rst_busy", {255'b0, busy}, 256'd0);
    check("rst_valid", {255'b0, valid}, 256'd0);
    check("rst_err", {255'b0, err}, 256'd0);
    check("rst_result", {128'b0, result}, 256'd0);
    rst = 1'b0;
    chk_on = 1'b1;

    // Pin the model with hand-derived values
    check("pin_ninv", {192'b0, nlow * ninv_good}, {192'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    check("pin_model_0", {128'b0, redc_model(256'd0)}, 256'd0);
    check("pin_model_R", {128'b0, redc_model(r_val)}, 256'd1);
    check("pin_model_5R", {128'b0, redc_model(r_val * 5)}, 256'd5);
    check("pin_model_n", {128'b0, redc_model({128'b0, N_MOD})}, 256'd0);

    // Refused start: no inverse available
    @(negedge clk);
    inv_valid = 1'b0;
    n_inv = ninv_good;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("err_pulse", {255'b0, err}, 256'd1);
    check("err_busy", {255'b0, busy}, 256'd0);
    check("err_valid", {255'b0, valid}, 256'd0);
    @(negedge clk);
    check("err_clear", {255'b0, err}, 256'd0);
    check("err_busy2", {255'b0, busy}, 256'd0);

    run_op(256'd0, 1'b1, 128'd0, 0, 1'b0);
    run_op(r_val, 1'b1, 128'd1, 0, 1'b0);
    run_op(r_val * 5, 1'b1, 128'd5, 5, 1'b0);
    run_op({128'b0, N_MOD}, 1'b1, 128'd0, 11, 1'b0);
    @(negedge clk);
    run_op(nr_m1, 1'b0, 128'd0, 0, 1'b0);
    run_op(r_val * 5, 1'b1, 128'd5, 0, 1'b1);

    // Asynchronous reset in the middle of the MAC rows
    @(negedge clk);
    t_in = r_val * 3;
    n = N_MOD;
    n_inv = ninv_good;
    inv_valid = 1'b1;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {255'b0, busy}, 256'd0);
    check("midrst_valid", {255'b0, valid}, 256'd0);
    check("midrst_err", {255'b0, err}, 256'd0);
    check("midrst_result", {128'b0, result}, 256'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    run_op(r_val, 1'b1, 128'd1, 0, 1'b0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
